// File: rtl/addern_seq_ctrl_pkg.sv
// Shared types and demo defaults for the sequenced slice adder.
package addern_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam int DEF_N     = 4;
  localparam int DEF_WORDS = 4;
endpackage

// File: rtl/addern_seq_ctrl_if.sv
// Requester-side bus of the sequenced adder: start/operands in, busy/done/results out.
interface addern_seq_ctrl_if
  import addern_seq_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WORDS = DEF_WORDS
);
  localparam int W = N * WORDS;

  logic         start;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  modport master (
    output start, cin, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, cin, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/addern_seq_ctrl_addern.sv
// Combinational N-bit ripple-carry slice adder.
module Addern #(
  parameter int N = 4
) (
  input  logic         cin,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] s,
  output logic         cout
);
  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[N];
endmodule

// File: rtl/addern_seq_ctrl.sv
// Adds two WORDS*N-bit operands through one N-bit slice, LS slice first, carry held in a register.
module addern_seq_ctrl
  import addern_seq_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WORDS = DEF_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  addern_seq_ctrl_if.slave bus
);
  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_q, b_q, sum_q;
  logic          cout_q, ovf_q;

  logic [N-1:0]  sx, sy, ss;
  logic          sc;
  logic          last;

  assign sx   = a_q[idx*N +: N];
  assign sy   = b_q[idx*N +: N];
  assign last = (idx == LAST);

  Addern #(.N(N)) u_slice (
    .cin  (carry),
    .x    (sx),
    .y    (sy),
    .s    (ss),
    .cout (sc)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            carry  <= bus.cin;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            idx    <= '0;
          end
        end
        RUN: begin
          sum_q[idx*N +: N] <= ss;
          carry             <= sc;
          // idx parks on the last slice instead of wrapping; IDLE re-arms it
          if (last) begin
            cout_q <= sc;
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (ss[N-1] != a_q[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == FIN);
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_addern_seq_ctrl.sv
// Randomized and directed bench for addern_seq_ctrl against an arithmetic reference.
module tb_addern_seq_ctrl;
  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  addern_seq_ctrl_if #(.N(N), .WORDS(WORDS)) bus ();

  addern_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on the whole operands
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output logic [W-1:0] s, output logic co, output logic ov);
    longint u;
    longint sg;
    u  = longint'(a) + longint'(b) + longint'(c);
    sg = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    s  = u[W-1:0];
    co = u[W];
    ov = (sg > 32767) || (sg < -32768);
  endtask

  // Caller is just past a negedge. disturb keeps start high and scrambles inputs through RUN/FIN.
  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic c, input bit disturb);
    logic [W-1:0] es;
    logic         eco, eov;
    model(a, b, c, es, eco, eov);
    bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1 && !disturb) bus.start = 1'b0;
      if (disturb && k <= 5) begin
        bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      end
      if (k == 6) bus.start = 1'b0;
      if (k <= WORDS) begin
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        chk({tag, ".done_early"}, 32'(bus.done), 32'd0);
      end else if (k == WORDS + 1) begin
        chk({tag, ".busy_fin"}, 32'(bus.busy), 32'd0);
        chk({tag, ".done"}, 32'(bus.done), 32'd1);
        chk({tag, ".sum"}, 32'(bus.sum), 32'(es));
        chk({tag, ".cout"}, 32'(bus.cout), 32'(eco));
        chk({tag, ".ovf"}, 32'(bus.overflow), 32'(eov));
      end else begin
        chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, ".idle_done"}, 32'(bus.done), 32'd0);
        chk({tag, ".hold_sum"}, 32'(bus.sum), 32'(es));
      end
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W-1:0] qa[3];
    logic [W-1:0] qb[3];
    logic [W-1:0] es;
    logic         eco, eov;

    bus.start = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.sum", 32'(bus.sum), 32'd0);
    chk("rst.cout", 32'(bus.cout), 32'd0);
    chk("rst.ovf", 32'(bus.overflow), 32'd0);
    // Reset dominates start
    bus.start = 1'b1;
    @(negedge clk);
    chk("rst_prio.busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    rst = 1'b0;

    op("d0", 16'h1234, 16'h1111, 1'b0, 1'b0);
    op("d1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op("d2", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    op("d3", 16'h8000, 16'h8000, 1'b0, 1'b0);
    op("d4", 16'h000F, 16'h0000, 1'b1, 1'b0);
    op("d5", 16'h000F, 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    chk("d5.no_rerun", 32'(bus.busy), 32'd0);
    chk("d5.sum_kept", 32'(bus.sum), 32'h0010);

    // Reset during the second RUN cycle aborts cleanly
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("abort.busy1", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.done", 32'(bus.done), 32'd0);
    chk("abort.sum", 32'(bus.sum), 32'd0);
    chk("abort.cout", 32'(bus.cout), 32'd0);
    chk("abort.ovf", 32'(bus.overflow), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort.no_done", 32'(bus.done), 32'd0);
    end
    op("post", 16'h0001, 16'h0002, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (i == 0) begin ra = 16'h8000; rb = 16'hFFFF; rc = 1'b0; end
      if (i == 1) begin ra = 16'h7FFF; rb = 16'h0000; rc = 1'b1; end
      op($sformatf("r%0d", i), ra, rb, rc, (i % 4) == 3);
    end

    // Start held high: one accept every WORDS+2 cycles, each with its own operands
    for (int i = 0; i < 3; i++) begin
      qa[i] = W'($urandom); qb[i] = W'($urandom);
    end
    bus.cin = 1'b0; bus.a = qa[0]; bus.b = qb[0]; bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      model(qa[i], qb[i], 1'b0, es, eco, eov);
      for (int k = 1; k <= WORDS + 2; k++) begin
        @(negedge clk);
        if (k == 1) begin bus.a = W'($urandom); bus.b = W'($urandom); end
        if (k <= WORDS) chk("b2b.busy", 32'(bus.busy), 32'd1);
        if (k == WORDS + 1) begin
          chk("b2b.done", 32'(bus.done), 32'd1);
          chk("b2b.sum", 32'(bus.sum), 32'(es));
          chk("b2b.cout", 32'(bus.cout), 32'(eco));
        end
        if (k == WORDS + 2) begin
          chk("b2b.gap", 32'(bus.busy | bus.done), 32'd0);
          if (i < 2) begin bus.a = qa[i+1]; bus.b = qb[i+1]; end
          else bus.start = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("b2b.stop", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
